// File: rtl/mecobo_pkg.sv
// mecobo_pkg: shared register map, control bit positions and scanner state encoding.
package mecobo_pkg;
  localparam int REG_MASK   = 0;
  localparam int REG_CTRL   = 1;
  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE} state_t;
endpackage

// File: rtl/sample_sync_fifo.sv
// sample_sync_fifo: single-clock FIFO with count and almost/full/empty flags.
// Ports: clk, rst (sync active-high), clr (sync clear, beats push/pop), push/din write side,
// pop/dout read side (dout shows the head word), count, empty, full, almost_empty, almost_full.
module sample_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty && !clr;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !clr;
  assign dout = mem[rp];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign almost_empty = count <= (AW+1)'(ALMOST_MARGIN);
  assign almost_full = count >= (AW+1)'(DEPTH - ALMOST_MARGIN);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sample_scanner.sv
// sample_scanner: round-robin channel sampler feeding a 32-bit FIFO read out as 16-bit half-words.
// Ports: clk, rst (sync active-high); cmd_bus_* register writes (mask at BASE+0, control at BASE+1);
// output_sample/channel_select request a channel, sample_data returns one cycle later;
// rd_en/data_out half-word read side; FIFO status flags, data_count and overflow_count.
module sample_scanner
  import mecobo_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DEPTH = 512,
  parameter int BASE_ADDR = 242,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_wr,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
  input  logic        rd_en,
  output logic [15:0] data_out,
  output logic        empty,
  output logic        almost_empty,
  output logic        full,
  output logic        almost_full,
  output logic [15:0] data_count,
  output logic [15:0] overflow_count
);
  state_t state;
  logic [NUM_CHANNELS-1:0] mask;
  logic run, half, wr, wr_mask, wr_ctrl, clr, go, capture, pop;
  logic [7:0] last, nxt;
  logic [31:0] head;
  logic [$clog2(DEPTH):0] cnt;
  assign wr = cmd_bus_en && cmd_bus_wr;
  assign wr_mask = wr && cmd_bus_addr == 16'(BASE_ADDR + REG_MASK);
  assign wr_ctrl = wr && cmd_bus_addr == 16'(BASE_ADDR + REG_CTRL);
  assign clr = wr_ctrl && cmd_bus_data[CTRL_CLEAR];
  assign go = run && |mask;
  assign capture = state == CAPTURE;
  assign pop = rd_en && half && !empty;
  assign data_count = 16'(cnt);
  assign data_out = empty ? 16'h0 : (half ? head[31:16] : head[15:0]);
  // Nearest enabled channel after the last serviced one; smaller offsets overwrite larger ones.
  always_comb begin
    nxt = last;
    for (int i = NUM_CHANNELS; i > 0; i--)
      if (mask[(int'(last) + i) % NUM_CHANNELS]) nxt = 8'((int'(last) + i) % NUM_CHANNELS);
  end
  sample_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH), .ALMOST_MARGIN(ALMOST_MARGIN)) fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(capture), .pop(pop), .din(sample_data),
    .dout(head), .count(cnt), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full)
  );
  // last starts at the top channel so the first scan after reset or clear begins at channel 0.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      run <= 1'b0;
      output_sample <= 1'b0;
      channel_select <= '0;
      last <= 8'(NUM_CHANNELS - 1);
      half <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (wr_mask) mask <= cmd_bus_data[NUM_CHANNELS-1:0];
      if (wr_ctrl) run <= cmd_bus_data[CTRL_RUN];
      output_sample <= 1'b0;
      if (state == SELECT) state <= CAPTURE;
      else if (go) begin
        state <= SELECT;
        output_sample <= 1'b1;
        channel_select <= nxt;
        last <= nxt;
      end else state <= IDLE;
      if (clr) begin
        last <= 8'(NUM_CHANNELS - 1);
        half <= 1'b0;
        overflow_count <= '0;
      end else begin
        if (rd_en && !empty) half <= ~half;
        if (capture && full && !pop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_sample_scanner.sv
// tb_sample_scanner: directed scoreboard bench for sample_scanner with a small FIFO.
module tb_sample_scanner;
  localparam int N = 16, D = 8, B = 242, M = 2;
  logic clk = 0, rst = 1;
  logic [15:0] cmd_bus_addr = '0;
  logic [31:0] cmd_bus_data = '0;
  logic cmd_bus_en = 0, cmd_bus_wr = 0, rd_en = 0;
  logic output_sample, empty, almost_empty, full, almost_full;
  logic [7:0] channel_select;
  logic [31:0] sample_data = '0;
  logic [15:0] data_out, data_count, overflow_count;
  logic [31:0] resp_base = 32'hA000_0000;
  logic [31:0] q[$];
  int vectors = 0, miscompares = 0, exp_last = N - 1, exp_mask = 0, exp_ovf = 0;

  sample_scanner #(.NUM_CHANNELS(N), .DEPTH(D), .BASE_ADDR(B), .ALMOST_MARGIN(M)) dut (
    .clk(clk), .rst(rst), .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr), .output_sample(output_sample),
    .channel_select(channel_select), .sample_data(sample_data), .rd_en(rd_en),
    .data_out(data_out), .empty(empty), .almost_empty(almost_empty), .full(full),
    .almost_full(almost_full), .data_count(data_count), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sample_data <= output_sample ? resp_base + 32'(channel_select) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    cmd_bus_addr = 16'(B + off);
    cmd_bus_data = d;
    cmd_bus_en = 1;
    cmd_bus_wr = 1;
    step();
    cmd_bus_en = 0;
    cmd_bus_wr = 0;
  endtask

  function automatic int next_ch(input int last, input int mask);
    for (int i = 1; i <= N; i++) if (mask[(last + i) % N]) return (last + i) % N;
    return last;
  endfunction

  task automatic clear_model();
    q.delete();
    exp_last = N - 1;
    exp_ovf = 0;
  endtask

  task automatic sample_n(input int n);
    int got, ch;
    got = 0;
    wr(1, 1);
    for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
      step();
      if (output_sample) begin
        ch = next_ch(exp_last, exp_mask);
        exp_last = ch;
        chk("channel_select", channel_select, 32'(ch));
        if (q.size() < D) q.push_back(resp_base + 32'(ch));
        else exp_ovf++;
        got++;
        if (got == n) wr(1, 0);
        else begin
          step();
          chk("output_sample pulse", output_sample, 0);
        end
      end
    end
    chk("sample count", got, n);
    step();
    step();
    chk("idle after stop", output_sample, 0);
    chk("data_count", data_count, q.size());
    chk("overflow_count", overflow_count, exp_ovf);
  endtask

  task automatic rd_word();
    logic [31:0] w;
    w = q.pop_front();
    chk("data_out low", data_out, {16'h0, w[15:0]});
    rd_en = 1;
    step();
    chk("data_out high", data_out, {16'h0, w[31:16]});
    step();
    rd_en = 0;
    chk("count after pop", data_count, q.size());
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) step();
    rst = 0;
    chk("rst output_sample", output_sample, 0);
    chk("rst channel_select", channel_select, 0);
    chk("rst data_count", data_count, 0);
    chk("rst overflow_count", overflow_count, 0);
    chk("rst flags", {empty, almost_empty, full, almost_full}, 4'b1100);
    chk("rst data_out", data_out, 0);
    // Two-channel round robin, stop on the fourth select.
    exp_mask = 5;
    wr(0, 5);
    sample_n(4);
    chk("mid flags", {empty, almost_empty, full, almost_full}, 4'b0000);
    while (q.size() > 0) rd_word();
    chk("drained flags", {empty, almost_empty, full, almost_full}, 4'b1100);
    chk("drained data_out", data_out, 0);
    // Reads on an empty FIFO leave everything alone.
    rd_en = 1;
    step();
    step();
    rd_en = 0;
    chk("empty read count", data_count, 0);
    exp_mask = 2;
    wr(0, 2);
    sample_n(1);
    rd_word();
    // Half-word order on a known word.
    wr(1, 2);
    clear_model();
    resp_base = 32'h1234_5678;
    exp_mask = 1;
    wr(0, 1);
    sample_n(1);
    rd_word();
    chk("empty after word", empty, 1);
    // Overflow with no reads.
    wr(1, 2);
    clear_model();
    resp_base = 32'hA000_0000;
    sample_n(12);
    chk("full flags", {empty, almost_empty, full, almost_full}, 4'b0011);
    // Full FIFO: high-half pop and push in the same cycle.
    rd_en = 1;
    step();
    rd_en = 0;
    w = q[0];
    chk("head high", data_out, {16'h0, w[31:16]});
    wr(1, 1);
    step();
    chk("select seen", output_sample, 1);
    wr(1, 0);
    rd_en = 1;
    step();
    rd_en = 0;
    void'(q.pop_front());
    exp_last = next_ch(exp_last, exp_mask);
    q.push_back(resp_base + 32'(exp_last));
    w = q[0];
    chk("full push+pop count", data_count, D);
    chk("full push+pop ovf", overflow_count, exp_ovf);
    chk("full push+pop full", full, 1);
    chk("new head low", data_out, {16'h0, w[15:0]});
    repeat (3) rd_word();
    // Clear beats a simultaneous read.
    rd_en = 1;
    wr(1, 2);
    rd_en = 0;
    clear_model();
    chk("clear count", data_count, 0);
    chk("clear empty", empty, 1);
    chk("clear ovf", overflow_count, 0);
    chk("clear data_out", data_out, 0);
    // Reset in the capture cycle stores nothing.
    wr(1, 1);
    step();
    chk("select before rst", output_sample, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    chk("rst mid count", data_count, 0);
    chk("rst mid empty", empty, 1);
    chk("rst mid idle", output_sample, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sample_scanner.md
SAMPLE_SCANNER -- requirements
Module: sample_scanner

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 16, number of sampled channels (1..32).
REQ-002 SHALL have parameter DEPTH, default 512, sample FIFO depth in 32-bit words (power of 2, >=4).
REQ-003 SHALL have parameter BASE_ADDR, default 242, first command-bus address owned by the block.
REQ-004 SHALL have parameter ALMOST_MARGIN, default 4, almost-full/almost-empty threshold in words.
REQ-005 SHALL have: clk  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have: cmd_bus_addr  in  16  command-bus address.
REQ-008 SHALL have: cmd_bus_data  in  32  command-bus write data.
REQ-009 SHALL have: cmd_bus_en / cmd_bus_wr  in  1 each  command-bus strobe and write qualifier.
REQ-010 SHALL have: output_sample  out  1  requests the selected channel to drive sample_data.
REQ-011 SHALL have: channel_select  out  8  channel index being sampled.
REQ-012 SHALL have: sample_data  in  32  channel response, valid exactly 1 cycle after output_sample.
REQ-013 SHALL have: rd_en  in  1  read strobe for one 16-bit half-word.
REQ-014 SHALL have: data_out  out  16  current half-word of FIFO head (low half first).
REQ-015 SHALL have: empty, almost_empty, full, almost_full  out  1 each  FIFO status.
REQ-016 SHALL have: data_count  out  16  words stored; overflow_count  out  16  dropped samples.

Function
REQ-017 Registers (write when cmd_bus_en & cmd_bus_wr & addr match): BASE+0 channel enable mask [NUM_CHANNELS-1:0]; BASE+1 control: bit0 run, bit1 clear (self-clearing pulse).
REQ-018 FSM states IDLE, SELECT, CAPTURE; IDLE->SELECT when run=1 and mask!=0; otherwise stay IDLE.
REQ-019 SELECT: output_sample=1 for exactly one cycle, channel_select=next enabled index after last serviced, round-robin, wrapping NUM_CHANNELS-1 -> 0; then CAPTURE.
REQ-020 CAPTURE: sample_data pushed as one 32-bit word if not full; if full, word dropped and overflow_count incremented, saturating at 0xFFFF.
REQ-021 CAPTURE -> SELECT if run=1 and mask!=0, else IDLE; steady-state throughput one sample per 2 cycles.
REQ-022 Run cleared or mask written during SELECT: the in-flight capture completes; new settings apply at the next state decision.
REQ-023 Single-bit mask: same channel sampled repeatedly.
REQ-024 data_out = head[15:0] until first rd_en, then head[31:16]; second rd_en pops the word; half pointer returns to low.
REQ-025 rd_en when empty is ignored; no pointer, count or half-pointer change.
REQ-026 Push and pop in same cycle: data_count unchanged; push accepted when full only if a pop occurs that cycle.
REQ-027 Pointers wrap modulo DEPTH; data_count ranges 0..DEPTH.
REQ-028 almost_full when data_count >= DEPTH-ALMOST_MARGIN; almost_empty when data_count <= ALMOST_MARGIN.
REQ-029 Clear empties FIFO, zeroes overflow_count and half pointer, resets round-robin to channel 0; clear beats a simultaneous push or pop.

Reset
REQ-030 On rst: state IDLE, mask 0, run 0, output_sample 0, channel_select 0, data_count 0, overflow_count 0, empty 1, almost_empty 1, full 0, almost_full 0, data_out 0.
REQ-031 rst mid-capture SHALL discard the in-flight sample; no partial word stored.

Structure
REQ-032 Register offsets, control bit positions and FSM state encoding SHALL live in shared package mecobo_pkg.
REQ-033 FIFO storage, pointers and flags SHALL be sub-module sample_sync_fifo (parameters WIDTH, DEPTH, ALMOST_MARGIN); scanner FSM and half-word read logic stay in sample_scanner.

Verification
REQ-034 mask=0x0005, run=1, channel returns 0xA0000000+index -> channel_select sequence 0,2,0,2...; FIFO words 0xA0000000,0xA0000002,...
REQ-035 DEPTH=8, no reads, mask=0x1, 12 samples -> full=1, data_count=8, overflow_count=4.
REQ-036 FIFO holds 0x12345678; two rd_en -> data_out 0x5678 then 0x1234; data_count 1->0; empty=1.
REQ-037 Full FIFO, push and rd_en high-half pop same cycle -> data_count stays DEPTH, overflow_count unchanged.
REQ-038 run cleared one cycle after output_sample -> one more word stored, then IDLE, output_sample stays 0.
REQ-039 Write clear with rd_en high and data_count=5 -> next cycle data_count=0, empty=1, overflow_count=0.
